// File: rtl/spi_text_buffer_pkg.sv
// Shared protocol constants and packet-FSM state encoding for the SPI text buffer.
`timescale 1ns/1ps
package spi_text_buffer_pkg;

  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] END_BYTE   = 8'hFE;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_CLEAR  = 8'h02;
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_COL   = 3'd2,
    ST_ROW   = 3'd3,
    ST_CHAR  = 3'd4,
    ST_ATTR  = 3'd5,
    ST_END   = 3'd6,
    ST_CLEAR = 3'd7
  } fsm_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises s_clk/ss/datain into master_clk,
// shifts MSB-first on each s_clk rising edge and flags partial bytes at ss release.
`timescale 1ns/1ps
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       master_clk,
  input  logic       reset_n,
  input  logic       s_clk,
  input  logic       ss,
  input  logic       datain,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic                   sclk_prev_r;
  logic                   ss_prev_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   valid_r;
  logic                   err_r;

  logic sclk_s;
  logic ss_s;
  logic din_s;
  logic sclk_rise_s;
  logic ss_fall_s;
  logic ss_rise_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign ss_s        = ss_sync_r[SYNC_STAGES-1];
  assign din_s       = din_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign ss_fall_s   = ~ss_s & ss_prev_r;
  assign ss_rise_s   = ss_s & ~ss_prev_r;

  // Synchroniser chains plus one delayed copy for edge detection; ss idles high.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r <= '0;
      ss_sync_r   <= '1;
      din_sync_r  <= '0;
      sclk_prev_r <= 1'b0;
      ss_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], s_clk};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], datain};
      sclk_prev_r <= sclk_s;
      ss_prev_r   <= ss_s;
    end
  end

  // Bit shifting and counting; the byte is complete when the 8th bit lands.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      if (ss_fall_s) begin
        bit_cnt_r <= 3'd0;
      end else if (ss_rise_s) begin
        err_r     <= (bit_cnt_r != 3'd0);
        bit_cnt_r <= 3'd0;
      end else if (!ss_s && sclk_rise_s) begin
        shift_r   <= {shift_r[6:0], din_s};
        valid_r   <= (bit_cnt_r == 3'd7);
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign byte_valid = valid_r;
  assign byte_data  = shift_r;
  assign frame_err  = err_r;

endmodule

// File: rtl/spi_text_buffer.sv
// SPI-loaded character/attribute frame buffer with a registered read port.
// Packets: FF 01 col row char attr FE (write cell) or FF 02 attr FE (clear screen).
`timescale 1ns/1ps
module spi_text_buffer
  import spi_text_buffer_pkg::*;
#(
  parameter int COLS        = 40,
  parameter int ROWS        = 15,
  parameter int ATTR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              s_clk,
  input  logic              ss,
  input  logic              datain,
  input  logic [7:0]        rd_col,
  input  logic [7:0]        rd_row,
  output logic [7:0]        rd_char,
  output logic [ATTR_W-1:0] rd_attr,
  output logic              busy,
  output logic              pkt_err,
  output logic              pkt_done
);

  localparam int                DEPTH     = COLS * ROWS;
  localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CELL_W    = 8 + ATTR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        COLS_B    = 8'(COLS);
  localparam logic [7:0]        ROWS_B    = 8'(ROWS);

  // Row-major cell address; callers only use it for in-range indices.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] col, input logic [7:0] row);
    int a;
    a = int'(row) * COLS + int'(col);
    return a[ADDR_W-1:0];
  endfunction

  logic             rx_valid_s;
  logic [7:0]       rx_byte_s;
  logic             rx_err_s;

  fsm_state_t        state_r, state_next;
  logic              is_clear_r;
  logic [7:0]        col_r, row_r, char_r;
  logic [ATTR_W-1:0] attr_r;
  logic              wr_pend_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic              busy_r, pkt_err_r, pkt_done_r;
  logic [7:0]        rd_char_r;
  logic [ATTR_W-1:0] rd_attr_r;

  logic err_s, done_s, commit_s;
  logic ld_cmd_s, ld_col_s, ld_row_s, ld_char_s, ld_attr_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [CELL_W-1:0] mem_data_s;
  logic [CELL_W-1:0] mem_r [0:DEPTH-1];

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .master_clk (master_clk),
    .reset_n    (reset_n),
    .s_clk      (s_clk),
    .ss         (ss),
    .datain     (datain),
    .byte_valid (rx_valid_s),
    .byte_data  (rx_byte_s),
    .frame_err  (rx_err_s)
  );

  // Packet FSM state register.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_next;
  end

  // Packet FSM next state, latch enables and error/done decisions.
  always_comb begin
    state_next = state_r;
    err_s      = rx_err_s;
    done_s     = 1'b0;
    commit_s   = 1'b0;
    ld_cmd_s   = 1'b0;
    ld_col_s   = 1'b0;
    ld_row_s   = 1'b0;
    ld_char_s  = 1'b0;
    ld_attr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid_s && rx_byte_s == START_BYTE) state_next = ST_CMD;
        else                                        state_next = ST_IDLE;
      end
      ST_CMD: begin
        if (!rx_valid_s)                    state_next = ST_CMD;
        else if (rx_byte_s == START_BYTE)   state_next = ST_CMD;
        else if (rx_byte_s == CMD_WRITE) begin
          ld_cmd_s = 1'b1; state_next = ST_COL;
        end else if (rx_byte_s == CMD_CLEAR) begin
          ld_cmd_s = 1'b1; state_next = ST_ATTR;
        end else begin
          err_s = 1'b1; state_next = ST_IDLE;
        end
      end
      ST_COL: begin
        if (!rx_valid_s)                  state_next = ST_COL;
        else if (rx_byte_s == START_BYTE) state_next = ST_CMD;
        else if (rx_byte_s < COLS_B) begin
          ld_col_s = 1'b1; state_next = ST_ROW;
        end else begin
          err_s = 1'b1; state_next = ST_IDLE;
        end
      end
      ST_ROW: begin
        if (!rx_valid_s)                  state_next = ST_ROW;
        else if (rx_byte_s == START_BYTE) state_next = ST_CMD;
        else if (rx_byte_s < ROWS_B) begin
          ld_row_s = 1'b1; state_next = ST_CHAR;
        end else begin
          err_s = 1'b1; state_next = ST_IDLE;
        end
      end
      ST_CHAR: begin
        if (rx_valid_s) begin
          ld_char_s = 1'b1; state_next = ST_ATTR;
        end else begin
          state_next = ST_CHAR;
        end
      end
      ST_ATTR: begin
        if (rx_valid_s) begin
          ld_attr_s = 1'b1; state_next = ST_END;
        end else begin
          state_next = ST_ATTR;
        end
      end
      ST_END: begin
        if (!rx_valid_s)                  state_next = ST_END;
        else if (rx_byte_s == START_BYTE) state_next = ST_CMD;
        else if (rx_byte_s == END_BYTE) begin
          done_s = 1'b1;
          if (is_clear_r) begin
            state_next = ST_CLEAR;
          end else begin
            commit_s   = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          err_s = 1'b1; state_next = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Bytes arriving mid-sweep are dropped and reported.
        if (rx_valid_s) err_s = 1'b1;
        else            err_s = rx_err_s;
        if (clr_addr_r == LAST_ADDR) state_next = ST_IDLE;
        else                         state_next = ST_CLEAR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Packet field latches, deferred write request, sweep counter and status pulses.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      is_clear_r <= 1'b0;
      col_r      <= 8'h00;
      row_r      <= 8'h00;
      char_r     <= 8'h00;
      attr_r     <= '0;
      wr_pend_r  <= 1'b0;
      clr_addr_r <= '0;
      busy_r     <= 1'b0;
      pkt_err_r  <= 1'b0;
      pkt_done_r <= 1'b0;
    end else begin
      if (ld_cmd_s)  is_clear_r <= (rx_byte_s == CMD_CLEAR);
      if (ld_col_s)  col_r      <= rx_byte_s;
      if (ld_row_s)  row_r      <= rx_byte_s;
      if (ld_char_s) char_r     <= rx_byte_s;
      if (ld_attr_s) attr_r     <= rx_byte_s[ATTR_W-1:0];
      wr_pend_r  <= commit_s;
      clr_addr_r <= (state_r == ST_CLEAR) ? clr_addr_r + ADDR_W'(1) : '0;
      busy_r     <= (state_next == ST_CLEAR);
      pkt_err_r  <= err_s;
      pkt_done_r <= done_s;
    end
  end

  // Storage write port: the clear sweep owns it, otherwise a committed cell write.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    mem_data_s = '0;
    if (state_r == ST_CLEAR) begin
      mem_we_s   = 1'b1;
      mem_addr_s = clr_addr_r;
      mem_data_s = {CLEAR_CHAR, attr_r};
    end else if (wr_pend_r) begin
      mem_we_s   = 1'b1;
      mem_addr_s = cell_addr(col_r, row_r);
      mem_data_s = {char_r, attr_r};
    end else begin
      mem_we_s   = 1'b0;
    end
  end

  // Frame storage; deliberately not reset so contents persist across reset.
  always_ff @(posedge master_clk) begin
    if (mem_we_s) mem_r[mem_addr_s] <= mem_data_s;
  end

  // Registered read port; a same-cycle write is not visible until the next read.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_char_r <= 8'h00;
      rd_attr_r <= '0;
    end else if (rd_col < COLS_B && rd_row < ROWS_B) begin
      {rd_char_r, rd_attr_r} <= mem_r[cell_addr(rd_col, rd_row)];
    end else begin
      rd_char_r <= 8'h00;
      rd_attr_r <= '0;
    end
  end

  assign rd_char  = rd_char_r;
  assign rd_attr  = rd_attr_r;
  assign busy     = busy_r;
  assign pkt_err  = pkt_err_r;
  assign pkt_done = pkt_done_r;

endmodule

// File: tb/tb_spi_text_buffer.sv
// Directed bench for spi_text_buffer: SPI packets, a frame-array model and a
// per-cycle read-port compare, plus a large-geometry instance for the basic write.
`timescale 1ns/1ps
module tb_spi_text_buffer;

  localparam int COLS = 40;
  localparam int ROWS = 15;

  logic       master_clk = 1'b0;
  logic       reset_n, s_clk, ss, datain;
  logic [7:0] rd_col, rd_row;
  logic [7:0] rd_char;
  logic [3:0] rd_attr;
  logic       busy, pkt_err, pkt_done;

  logic       en2, ss2;
  logic [7:0] rd_col2, rd_row2, rd_char2, rd_attr2;
  logic       busy2, pkt_err2, pkt_done2;
  assign ss2 = ss | ~en2;

  always #5 master_clk = ~master_clk;

  spi_text_buffer dut (
    .master_clk(master_clk), .reset_n(reset_n), .s_clk(s_clk), .ss(ss), .datain(datain),
    .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char), .rd_attr(rd_attr),
    .busy(busy), .pkt_err(pkt_err), .pkt_done(pkt_done));

  spi_text_buffer #(.COLS(80), .ROWS(30), .ATTR_W(8)) dut2 (
    .master_clk(master_clk), .reset_n(reset_n), .s_clk(s_clk), .ss(ss2), .datain(datain),
    .rd_col(rd_col2), .rd_row(rd_row2), .rd_char(rd_char2), .rd_attr(rd_attr2),
    .busy(busy2), .pkt_err(pkt_err2), .pkt_done(pkt_done2));

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural frame model: what each cell must hold after the packets sent so far.
  logic [7:0] m_char [0:COLS*ROWS-1];
  logic [3:0] m_attr [0:COLS*ROWS-1];

  function automatic int exp_char(input int c, input int r);
    if (c < COLS && r < ROWS) return int'(m_char[r*COLS+c]);
    else return 0;
  endfunction
  function automatic int exp_attr(input int c, input int r);
    if (c < COLS && r < ROWS) return int'(m_attr[r*COLS+c]);
    else return 0;
  endfunction
  task automatic model_write(input int c, input int r, input logic [7:0] ch, input logic [3:0] at);
    m_char[r*COLS+c] = ch;
    m_attr[r*COLS+c] = at;
  endtask
  task automatic model_clear(input logic [3:0] at);
    for (int i = 0; i < COLS*ROWS; i++) begin
      m_char[i] = 8'h20;
      m_attr[i] = at;
    end
  endtask

  // Pulse counters and busy run-length monitor.
  int done_cnt = 0, err_cnt = 0, done2_cnt = 0, err2_cnt = 0;
  int busy_run = 0, last_busy = 0;
  always @(negedge master_clk) begin
    if (pkt_done)  done_cnt++;
    if (pkt_err)   err_cnt++;
    if (pkt_done2) done2_cnt++;
    if (pkt_err2 || busy2) err2_cnt++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  // Per-cycle read-port compare against the model, one cycle after the address.
  logic       cmp_en = 1'b0;
  logic       cap_v = 1'b0;
  logic [7:0] cap_col, cap_row;
  always @(posedge master_clk) begin
    cap_col <= rd_col;
    cap_row <= rd_row;
    cap_v   <= cmp_en;
  end
  always @(negedge master_clk) begin
    if (cap_v && reset_n) begin
      chk($sformatf("cell(%0d,%0d) char", cap_col, cap_row), int'(rd_char), exp_char(cap_col, cap_row));
      chk($sformatf("cell(%0d,%0d) attr", cap_col, cap_row), int'(rd_attr), exp_attr(cap_col, cap_row));
    end
  end

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      datain = b[i];
      #40 s_clk = 1'b1;
      #40 s_clk = 1'b0;
    end
  endtask
  task automatic frame_begin();
    ss = 1'b0;
    #80;
  endtask
  task automatic frame_end();
    #40 ss = 1'b1;
    #160;
  endtask
  // Sends n bytes in one ss frame, first byte in the most significant used position.
  task automatic send(input logic [95:0] v, input int n);
    frame_begin();
    for (int i = 0; i < n; i++) spi_byte(v[(n-1-i)*8 +: 8]);
    frame_end();
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] ch, output logic [3:0] at);
    @(posedge master_clk) #1;
    rd_col = 8'(c);
    rd_row = 8'(r);
    @(posedge master_clk) #1;
    ch = rd_char;
    at = rd_attr;
  endtask

  task automatic sweep();
    for (int r = 0; r <= ROWS; r++)
      for (int c = 0; c <= COLS; c++) begin
        @(posedge master_clk) #1;
        rd_col = 8'(c);
        rd_row = 8'(r);
        cmp_en = 1'b1;
      end
    @(posedge master_clk) #1;
    cmp_en = 1'b0;
    @(posedge master_clk) #1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(posedge master_clk);
      n++;
    end
    while (busy === 1'b1 && n < 2000) begin
      @(posedge master_clk);
      n++;
    end
    if (n >= 2000 || busy !== 1'b0) chk({name, " sweep end"}, 0, 1);
    repeat (3) @(negedge master_clk);
    chk({name, " busy cycles"}, last_busy, 600);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, e0, d20;
    logic [7:0] ch;
    logic [3:0] at;

    reset_n = 1'b0; ss = 1'b1; s_clk = 1'b0; datain = 1'b0;
    rd_col = 8'd0; rd_row = 8'd0; en2 = 1'b1;
    rd_col2 = 8'd5; rd_row2 = 8'd3;
    repeat (3) @(negedge master_clk);
    chk("reset rd_char", int'(rd_char), 0);
    chk("reset rd_attr", int'(rd_attr), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pkt_err", int'(pkt_err), 0);
    chk("reset pkt_done", int'(pkt_done), 0);
    @(posedge master_clk) #1 reset_n = 1'b1;
    repeat (5) @(posedge master_clk);

    // Single cell write, both geometries.
    d0 = done_cnt; e0 = err_cnt; d20 = done2_cnt;
    send(96'hFF0105034107FE, 7);
    repeat (5) @(posedge master_clk);
    chk("write pkt_done count", done_cnt - d0, 1);
    chk("write pkt_err count", err_cnt - e0, 0);
    chk("big pkt_done count", done2_cnt - d20, 1);
    read_cell(5, 3, ch, at);
    chk("write (5,3) char", int'(ch), 8'h41);
    chk("write (5,3) attr", int'(at), 4'h7);
    @(negedge master_clk);
    chk("big (5,3) char", int'(rd_char2), 8'h41);
    chk("big (5,3) attr", int'(rd_attr2), 8'h07);
    en2 = 1'b0;

    // Clear screen with attribute 3.
    d0 = done_cnt; e0 = err_cnt;
    send(96'hFF0203FE, 4);
    wait_clear("clear3");
    chk("clear pkt_done count", done_cnt - d0, 1);
    chk("clear pkt_err count", err_cnt - e0, 0);
    model_clear(4'h3);
    read_cell(0, 0, ch, at);
    chk("clear (0,0) char", int'(ch), 8'h20);
    chk("clear (0,0) attr", int'(at), 4'h3);
    read_cell(39, 14, ch, at);
    chk("clear (39,14) char", int'(ch), 8'h20);
    read_cell(5, 3, ch, at);
    chk("clear (5,3) char", int'(ch), 8'h20);
    read_cell(255, 0, ch, at);
    chk("oob col255 char", int'(ch), 0);
    read_cell(0, 15, ch, at);
    chk("oob row15 attr", int'(at), 0);
    sweep();

    // Column out of range, then re-sync mid packet.
    d0 = done_cnt; e0 = err_cnt;
    send(96'hFF0128, 3);
    repeat (5) @(posedge master_clk);
    chk("bad col pkt_err count", err_cnt - e0, 1);
    chk("bad col pkt_done count", done_cnt - d0, 0);
    e0 = err_cnt;
    send(96'hFF0100FF0102024201FE, 10);
    repeat (5) @(posedge master_clk);
    chk("resync pkt_err count", err_cnt - e0, 0);
    chk("resync pkt_done count", done_cnt - d0, 1);
    model_write(2, 2, 8'h42, 4'h1);
    read_cell(2, 2, ch, at);
    chk("resync (2,2) char", int'(ch), 8'h42);
    sweep();

    // Partial byte, then a normal packet.
    d0 = done_cnt; e0 = err_cnt;
    frame_begin();
    for (int i = 0; i < 5; i++) begin
      datain = 1'b1;
      #40 s_clk = 1'b1;
      #40 s_clk = 1'b0;
    end
    frame_end();
    repeat (5) @(posedge master_clk);
    chk("partial pkt_err count", err_cnt - e0, 1);
    send(96'hFF010707550AFE, 7);
    repeat (5) @(posedge master_clk);
    chk("after partial pkt_done", done_cnt - d0, 1);
    chk("after partial pkt_err", err_cnt - e0, 1);
    model_write(7, 7, 8'h55, 4'hA);
    read_cell(7, 7, ch, at);
    chk("after partial (7,7) attr", int'(at), 4'hA);

    // Byte arriving during a clear sweep.
    d0 = done_cnt; e0 = err_cnt;
    send(96'hFF0205FE, 4);
    send(96'h11, 1);
    wait_clear("clear5");
    chk("clear-busy pkt_err count", err_cnt - e0, 1);
    chk("clear-busy pkt_done count", done_cnt - d0, 1);
    model_clear(4'h5);
    sweep();

    // Reset between ROW and CHAR bytes.
    d0 = done_cnt; e0 = err_cnt;
    rd_col = 8'd7; rd_row = 8'd7;
    frame_begin();
    spi_byte(8'hFF); spi_byte(8'h01); spi_byte(8'h04); spi_byte(8'h04);
    @(posedge master_clk) #1 reset_n = 1'b0;
    @(negedge master_clk);
    chk("midreset rd_char", int'(rd_char), 0);
    chk("midreset rd_attr", int'(rd_attr), 0);
    chk("midreset busy", int'(busy), 0);
    repeat (2) @(posedge master_clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge master_clk);
    spi_byte(8'h33); spi_byte(8'h02); spi_byte(8'hFE);
    frame_end();
    repeat (5) @(posedge master_clk);
    chk("midreset pkt_done count", done_cnt - d0, 0);
    chk("midreset pkt_err count", err_cnt - e0, 0);
    read_cell(4, 4, ch, at);
    chk("midreset (4,4) char", int'(ch), 8'h20);
    sweep();

    chk("big instance quiet", err2_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
